clk_enable_gen: RTL and testbench
=================================

// Module: clk_enable_gen
// PURPOSE
//  Multi-channel clock-enable generator with PLL-lock supervision. Runs on the PLL output clock.
//  Holds the system reset until the PLL lock is stable, then emits phase-aligned single-cycle
//  enable pulses at per-channel divide ratios. Replaces ad-hoc fixed divisors downstream of
//  the PLL wrapper.
// PARAMETERS
//  NCH          4             number of enable channels (1..16)
//  DIV_W        8             divider width; ratio range 1..2**DIV_W-1
//  DIV_INIT     {NCH{8'd2}}   packed NCH*DIV_W reset ratios; channel i in bits [i*DIV_W +: DIV_W]
//  LOCK_STABLE  1024          consecutive synced-lock cycles required before reset release begins
//  RST_HOLD     16            extra cycles rst_out stays high after lock is deemed stable
// PORTS
//  clk          in   1              PLL output clock
//  rst          in   1              asynchronous, active-high reset
//  pll_lock     in   1              raw PLL LOCK, asynchronous to clk
//  div_wr_valid in   1              divider-update request
//  div_wr_ready out  1              update accepted when valid&&ready
//  div_wr_ch    in   $clog2(NCH)    target channel (clog2 floored at 1)
//  div_wr_val   in   DIV_W          new ratio; 0 is treated as 1
//  ce           out  NCH            per-channel one-cycle enable pulses
//  rst_out      out  1              synchronous active-high system reset
//  locked       out  1              high only in RUN
// BEHAVIOUR
//  - Reset values: ce=0, rst_out=1, locked=0, div_wr_ready=0, FSM=WAIT_LOCK, counters=0,
//    ratios=DIV_INIT.
//  - pll_lock passes through a 2-FF synchroniser (lock_s); 2-cycle latency.
//  - FSM:
//    WAIT_LOCK: stab_cnt++ while lock_s=1, else 0. Goes to HOLD when stab_cnt==LOCK_STABLE-1.
//    HOLD: hold_cnt counts RST_HOLD cycles, then goes to RUN.
//    RUN: rst_out=0, locked=1.
//    In any state, lock_s=0 sends the FSM to WAIT_LOCK next cycle; rst_out=1 and ce=0 from that cycle.
//  - Channels: cnt_i counts 0..ratio_i-1 and wraps. ce[i]=1 in the cycle cnt_i==ratio_i-1 (RUN only).
//    All cnt_i clear on entry to RUN, so channels are phase-aligned. The first ce[i] comes
//    ratio_i cycles after locked rises.
//    ratio 1 (or 0): ce[i] is constant 1 in RUN.
//  - ce is registered and mutually independent; outside RUN, cnt_i are held at 0.
//  - Update handshake: one pending slot. div_wr_ready = !pending && !rst.
//    On accept, ch/val are latched. Outside RUN the update applies next cycle.
//    In RUN it applies on the target channel's wrap cycle (the cycle ce fires), so no runt period.
//    The counter restarts at 0 with the new ratio. pending clears in the apply cycle.
//    div_wr_ch>=NCH: the request is accepted and dropped.
//  - Reset mid-operation: everything returns to reset values asynchronously; a pending update is lost.
// CONFIGURATION
//  CLKGEN_DYN_DIV_EN defined: update handshake as above.
//  Undefined: div_wr_ready tied 0; div_wr_* ignored; ratios are constant DIV_INIT
//    (no ratio registers, no pending slot).
// STRUCTURE
//  clkgen_pkg: state enum (WAIT_LOCK, HOLD, RUN), function clamp_ratio (0->1),
//    localparam for synchroniser depth (2).
//  Sub-module clkgen_div_ch (one per channel, generate loop):
//    inputs run, ratio, load, load_val; output ce.
//  Top holds the synchroniser, FSM, and update slot.
// TESTING
//  1 Lock bring-up: LOCK_STABLE=8, RST_HOLD=4; raise pll_lock at t0 -> rst_out falls and
//    locked rises at t0+2+8+4 (±1); ce stays 0 before that.
//  2 Ratios {1,2,3,5}: ce[0] constant 1. ce[1] period 2, ce[2] period 3, ce[3] period 5.
//    First pulses at cycles 1,2,3,5 after locked.
//  3 Lock glitch: drop pll_lock for 1 cycle in RUN -> within 3 cycles rst_out=1, locked=0, ce=0.
//    Full re-stabilisation follows.
//  4 Dynamic update (macro on): ch2 ratio 3->7 written mid-period -> current 3-period completes,
//    then period 7. div_wr_ready is low until the apply cycle. A second write while pending stalls.
//  5 Edge values: write ratio 0 -> behaves as 1. Write ch=NCH -> accepted, no channel changes.
//  6 Macro off: div_wr_valid=1 held -> div_wr_ready stays 0; ratios stay DIV_INIT.
//    Async rst mid-RUN -> all outputs immediately at reset values.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared definitions for the clock-enable generator.
//  - state_t      : supervisor states (WAIT_LOCK, HOLD, RUN)
//  - SYNC_STAGES  : depth of the pll_lock synchroniser
//  - clamp_ratio  : maps a ratio of 0 onto 1 (valid for DIV_W up to MAX_DIV_W)
package clkgen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_DIV_W   = 16;

    function automatic logic [MAX_DIV_W-1:0] clamp_ratio(input logic [MAX_DIV_W-1:0] r);
        return (r == '0) ? MAX_DIV_W'(1) : r;
    endfunction

endpackage

// File: rtl/clkgen_div_ch.sv
// One enable channel: a wrapping counter 0..ratio-1 that raises a registered
// one-cycle ce when the counter wraps.
// Ports:
//  clk, rst   clock and asynchronous active-high reset
//  run        supervisor is in RUN this cycle (counter held at 0 otherwise)
//  run_next   supervisor stays in RUN next cycle (suppresses ce on exit)
//  ratio      reset/default ratio (0 is treated as 1)
//  load       an update for this channel is pending
//  load_val   pending ratio value
//  load_done  the pending update is applied this cycle
//  ce         registered enable pulse
// Build option CLKGEN_DYN_DIV_EN: when defined the ratio lives in a register
// that load/load_val can update; otherwise the ratio is the constant input.
module clkgen_div_ch
    import clkgen_pkg::*;
#(
    parameter int DIV_W = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             run_next,
    input  logic [DIV_W-1:0] ratio,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             load_done,
    output logic             ce
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic [DIV_W-1:0] ratio_eff;
    logic             wrap;

`ifdef CLKGEN_DYN_DIV_EN
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic             apply;

    assign ratio_eff = ratio_q;
    // Outside RUN the update is taken immediately; in RUN only at the wrap
    // so the period in progress always completes with its old length.
    assign apply     = load && (!run || wrap);
    assign load_done = apply;

    always_comb begin
        ratio_d = ratio_q;
        if (apply) begin
            ratio_d = DIV_W'(clamp_ratio(MAX_DIV_W'(load_val)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ratio_q <= DIV_W'(clamp_ratio(MAX_DIV_W'(ratio)));
        end else begin
            ratio_q <= ratio_d;
        end
    end
`else
    logic unused_load;

    assign ratio_eff   = DIV_W'(clamp_ratio(MAX_DIV_W'(ratio)));
    assign load_done   = 1'b0;
    assign unused_load = ^{load, load_val};
`endif

    assign wrap = (cnt_q == ratio_eff - 1'b1);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Registered pulse; dropped if RUN is being left so ce is 0 from
        // the first non-RUN cycle.
        ce_d = run && run_next && wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with PLL-lock supervision.
// Holds rst_out until the synchronised PLL lock has been stable for
// LOCK_STABLE cycles plus RST_HOLD cycles, then emits phase-aligned enable
// pulses, one channel per clkgen_div_ch instance.
// Ports:
//  clk           PLL output clock
//  rst           asynchronous active-high reset
//  pll_lock      raw PLL lock (asynchronous, synchronised here)
//  div_wr_valid  ratio update request
//  div_wr_ready  update accepted when valid && ready (one pending slot)
//  div_wr_ch     target channel; values >= NCH are accepted and dropped
//  div_wr_val    new ratio; 0 is treated as 1
//  ce            per-channel one-cycle enables (RUN only)
//  rst_out       synchronous active-high system reset
//  locked        high only in RUN
// Build option CLKGEN_DYN_DIV_EN: enables the ratio-update handshake. When
// undefined div_wr_ready is 0, div_wr_* are ignored and ratios are DIV_INIT.
module clk_enable_gen
    import clkgen_pkg::*;
#(
    parameter int                   NCH         = 4,
    parameter int                   DIV_W       = 8,
    parameter logic [NCH*DIV_W-1:0] DIV_INIT    = {NCH{DIV_W'(2)}},
    parameter int                   LOCK_STABLE = 1024,
    parameter int                   RST_HOLD    = 16,
    localparam int                  CH_W        = (NCH > 1) ? $clog2(NCH) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             div_wr_valid,
    output logic             div_wr_ready,
    input  logic [CH_W-1:0]  div_wr_ch,
    input  logic [DIV_W-1:0] div_wr_val,
    output logic [NCH-1:0]   ce,
    output logic             rst_out,
    output logic             locked
);

    localparam int STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    // ---------------- lock synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lock_s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
    assign lock_s = sync_q[SYNC_STAGES-1];

    // ---------------- supervisor FSM ----------------
    state_t            state_q, state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              run, run_next;

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        if (!lock_s) begin
            // Any loss of lock restarts the whole bring-up sequence.
            state_d    = WAIT_LOCK;
            stab_cnt_d = '0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (stab_cnt_q == STAB_W'(LOCK_STABLE - 1)) begin
                        state_d    = HOLD;
                        stab_cnt_d = '0;
                    end else begin
                        stab_cnt_d = stab_cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                        state_d    = RUN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    assign run      = (state_q == RUN);
    assign run_next = (state_d == RUN);
    assign locked   = run;
    assign rst_out  = !run;

    // ---------------- update slot ----------------
    logic [NCH-1:0]   load_done_w;
    logic [DIV_W-1:0] load_val_w;

`ifdef CLKGEN_DYN_DIV_EN
    logic             pending_q, pending_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;

    assign div_wr_ready = !pending_q && !rst;
    assign load_val_w   = pend_val_q;

    always_comb begin
        pending_d  = pending_q;
        pend_ch_d  = pend_ch_q;
        pend_val_d = pend_val_q;
        if (pending_q && |load_done_w) begin
            pending_d = 1'b0;
        end
        // Accept only happens with the slot empty, so it never collides
        // with the clear above. Out-of-range channels are simply not stored.
        if (div_wr_valid && div_wr_ready && (int'(div_wr_ch) < NCH)) begin
            pending_d  = 1'b1;
            pend_ch_d  = div_wr_ch;
            pend_val_d = div_wr_val;
        end
    end
`else
    logic unused_wr;

    assign div_wr_ready = 1'b0;
    assign load_val_w   = '0;
    assign unused_wr    = ^{div_wr_valid, div_wr_ch, div_wr_val, load_done_w};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= WAIT_LOCK;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
`ifdef CLKGEN_DYN_DIV_EN
            pending_q  <= 1'b0;
            pend_ch_q  <= '0;
            pend_val_q <= '0;
`endif
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef CLKGEN_DYN_DIV_EN
            pending_q  <= pending_d;
            pend_ch_q  <= pend_ch_d;
            pend_val_q <= pend_val_d;
`endif
        end
    end

    // ---------------- channels ----------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic ch_load;
`ifdef CLKGEN_DYN_DIV_EN
        assign ch_load = pending_q && (pend_ch_q == CH_W'(gi));
`else
        assign ch_load = 1'b0;
`endif
        clkgen_div_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .run       (run),
            .run_next  (run_next),
            .ratio     (DIV_INIT[gi*DIV_W +: DIV_W]),
            .load      (ch_load),
            .load_val  (load_val_w),
            .load_done (load_done_w[gi]),
            .ce        (ce[gi])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
module tb_clk_enable_gen;

    localparam int NCH   = 5;
    localparam int DIV_W = 8;
    localparam int CH_W  = 3;
    localparam int LS    = 8;
    localparam int RH    = 4;
    localparam logic [NCH*DIV_W-1:0] DIV_INIT = 40'h04_05_03_02_01;
`ifdef CLKGEN_DYN_DIV_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pll_lock = 1'b0;
    logic             div_wr_valid = 1'b0;
    logic             div_wr_ready;
    logic [CH_W-1:0]  div_wr_ch = '0;
    logic [DIV_W-1:0] div_wr_val = '0;
    logic [NCH-1:0]   ce;
    logic             rst_out;
    logic             locked;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    clk_enable_gen #(
        .NCH         (NCH),
        .DIV_W       (DIV_W),
        .DIV_INIT    (DIV_INIT),
        .LOCK_STABLE (LS),
        .RST_HOLD    (RH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .div_wr_valid (div_wr_valid),
        .div_wr_ready (div_wr_ready),
        .div_wr_ch    (div_wr_ch),
        .div_wr_val   (div_wr_val),
        .ce           (ce),
        .rst_out      (rst_out),
        .locked       (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int init_ratio(input int i);
        logic [NCH*DIV_W-1:0] v;
        int r;
        v = DIV_INIT;
        r = int'(v[i*DIV_W +: DIV_W]);
        return (r == 0) ? 1 : r;
    endfunction

    // ---------------- behavioural model ----------------
    // Locked iff the synchronised lock has been high for LS+RH consecutive
    // cycles before this one. In RUN, channel i pulses at times np[i]
    // (measured from the first RUN cycle), each pulse scheduling the next one
    // ratio later; a pending update takes effect one cycle before a pulse.
    int ratio_m [NCH];
    int np      [NCH];
    int t_m = 0;
    int run_len = 0;
    int pch = 0;
    int pval = 0;
    bit pend_m = 1'b0;
    bit ph0 = 1'b0;
    bit ph1 = 1'b0;
    bit was_locked = 1'b0;

    always @(negedge clk) begin
        logic [NCH-1:0] ce_m;
        bit lock_s_m;
        bit locked_m;
        bit ready_m;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                ratio_m[i] = init_ratio(i);
                np[i] = 0;
            end
            pend_m = 1'b0; ph0 = 1'b0; ph1 = 1'b0;
            run_len = 0; was_locked = 1'b0; t_m = 0;
            chk("rst_ce", 32'(ce), 32'd0);
            chk("rst_locked", 32'(locked), 32'd0);
            chk("rst_rst_out", 32'(rst_out), 32'd1);
            chk("rst_ready", 32'(div_wr_ready), 32'd0);
        end else begin
            lock_s_m = ph1;
            locked_m = (run_len >= LS + RH);
            if (locked_m && !was_locked) begin
                t_m = 0;
                for (int i = 0; i < NCH; i++) np[i] = ratio_m[i];
            end
            ce_m = '0;
            for (int i = 0; i < NCH; i++) begin
                if (locked_m && t_m == np[i]) begin
                    ce_m[i] = 1'b1;
                    np[i] = np[i] + ratio_m[i];
                end
            end
            ready_m = DYN && !pend_m;
            chk("ce", 32'(ce), 32'(ce_m));
            chk("locked", 32'(locked), 32'(locked_m));
            chk("rst_out", 32'(rst_out), 32'(!locked_m));
            chk("ready", 32'(div_wr_ready), 32'(ready_m));
            if (pend_m && (!locked_m || t_m == np[pch] - 1)) begin
                ratio_m[pch] = pval;
                pend_m = 1'b0;
            end
            if (div_wr_valid && ready_m && int'(div_wr_ch) < NCH) begin
                pend_m = 1'b1;
                pch = int'(div_wr_ch);
                pval = (div_wr_val == 0) ? 1 : int'(div_wr_val);
            end
            t_m++;
            was_locked = locked_m;
            run_len = lock_s_m ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
            ph1 = ph0;
            ph0 = pll_lock;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_locked(input logic want, output int at);
        at = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (locked === want) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("wait_locked", 32'(locked), 32'(want));
    endtask

    task automatic do_write(input int ch, input int val, output int acc);
        acc = -1;
        div_wr_valid = 1'b1;
        div_wr_ch = CH_W'(ch);
        div_wr_val = DIV_W'(val);
        for (int k = 0; k < 60; k++) begin
            if (div_wr_ready) begin
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) chk("write_accept", 32'(div_wr_ready), 32'd1);
        @(posedge clk); #1;
        div_wr_valid = 1'b0;
    endtask

    initial begin : stim
        int c0, c1, at, lk;
        int first [NCH];
        int exp_first [NCH];
        int glitch;
        exp_first = '{1, 2, 3, 5, 4};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_out", 32'(rst_out), 32'd1);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_ce", 32'(ce), 32'd0);
        chk("reset_ready", 32'(div_wr_ready), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // bring-up: locked exactly 2 + LS + RH cycles after lock is raised
        pll_lock = 1'b1;
        c0 = cyc;
        wait_locked(1'b1, lk);
        chk("bringup_latency", 32'(lk - c0), 32'(2 + LS + RH));

        // first pulses after locked
        for (int i = 0; i < NCH; i++) first[i] = -1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NCH; i++)
                if (ce[i] && first[i] < 0) first[i] = cyc - lk;
        end
        for (int i = 0; i < NCH; i++) chk($sformatf("first_pulse_ch%0d", i), 32'(first[i]), 32'(exp_first[i]));

        // one-cycle lock glitch
        @(posedge clk); #1;
        pll_lock = 1'b0;
        c1 = cyc;
        @(posedge clk); #1;
        pll_lock = 1'b1;
        wait_locked(1'b0, at);
        chk("glitch_drop_latency", 32'(at - c1), 32'd3);
        wait_locked(1'b1, at);
        chk("glitch_relock_latency", 32'(at - (c1 + 1)), 32'(2 + LS + RH));

`ifdef CLKGEN_DYN_DIV_EN
        begin : dyn_tests
            int p, first_ready, np2, pulse [2];
            p = -1;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (ce[2]) begin p = cyc; break; end
            end
            chk("find_ch2_pulse", 32'(p >= 0), 32'd1);
            div_wr_valid = 1'b1; div_wr_ch = 3'd2; div_wr_val = 8'd7;
            @(posedge clk); #1;
            chk("ready_while_pending", 32'(div_wr_ready), 32'd0);
            div_wr_ch = 3'd1; div_wr_val = 8'd3;
            first_ready = -1; np2 = 0; pulse[0] = -1; pulse[1] = -1;
            for (int k = 0; k < 14; k++) begin
                if (div_wr_valid && div_wr_ready && first_ready < 0) first_ready = cyc;
                @(posedge clk); #1;
                if (first_ready >= 0) div_wr_valid = 1'b0;
                if (ce[2] && np2 < 2) begin pulse[np2] = cyc - p; np2++; end
            end
            chk("ready_after_apply", 32'(first_ready - p), 32'd3);
            chk("ch2_old_period_end", 32'(pulse[0]), 32'd3);
            chk("ch2_new_period", 32'(pulse[1]), 32'd10);

            // ratio 0 behaves as 1
            do_write(3, 0, at);
            repeat (12) @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                chk("ratio0_as_1", 32'(ce[3]), 32'd1);
            end
            // out-of-range channel: accepted, nothing held pending
            do_write(7, 9, at);
            chk("drop_ready", 32'(div_wr_ready), 32'd1);
        end
`else
        begin : static_tests
            int seen_ready, p3a, p3b;
            seen_ready = 0; p3a = -1; p3b = -1;
            for (int k = 0; k < 30; k++) begin
                div_wr_valid = 1'b1;
                div_wr_ch = CH_W'($urandom_range(0, 4));
                div_wr_val = DIV_W'($urandom_range(0, 9));
                @(posedge clk); #1;
                if (div_wr_ready) seen_ready++;
                if (ce[3]) begin
                    if (p3a < 0) p3a = cyc;
                    else if (p3b < 0) p3b = cyc;
                end
            end
            div_wr_valid = 1'b0;
            chk("ready_tied_low", 32'(seen_ready), 32'd0);
            chk("ch3_period_init", 32'(p3b - p3a), 32'd5);
        end
`endif

        // randomized traffic with occasional lock glitches
        glitch = 0;
        for (int k = 0; k < 800; k++) begin
            @(posedge clk); #1;
            div_wr_valid = ($urandom_range(0, 3) == 0);
            div_wr_ch = CH_W'($urandom_range(0, 7));
            div_wr_val = DIV_W'($urandom_range(0, 9));
            if (glitch > 0) begin
                glitch--;
                if (glitch == 0) pll_lock = 1'b1;
            end else if ($urandom_range(0, 249) == 0) begin
                pll_lock = 1'b0;
                glitch = $urandom_range(1, 3);
            end
        end
        pll_lock = 1'b1;
        div_wr_valid = 1'b0;

        // asynchronous reset mid-RUN
        wait_locked(1'b1, at);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_rst_out", 32'(rst_out), 32'd1);
        chk("async_rst_locked", 32'(locked), 32'd0);
        chk("async_rst_ce", 32'(ce), 32'd0);
        chk("async_rst_ready", 32'(div_wr_ready), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = cyc;
        wait_locked(1'b1, at);
        chk("relock_after_rst", 32'(at - c0), 32'(2 + LS + RH));
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            div_wr_valid = ($urandom_range(0, 2) == 0);
            div_wr_ch = CH_W'($urandom_range(0, 7));
            div_wr_val = DIV_W'($urandom_range(0, 6));
        end
        div_wr_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
